seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller for the common-anode display bank, the successor to the fixed 4-digit ring select shifter. Generates one-hot digit select plus matching segment pattern per slot, with a programmable slot rate, an anti-ghosting guard interval, a per-digit enable mask, leading-zero suppression, decimal points and a tear-free double-buffered data load. Sits between the measurement/formatting logic and the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (guard + on time); must be > GUARD_CYCLES
GUARD_CYCLES, 2, cycles per slot with all digits off before the select changes (>=1)
SEL_ACTIVE_LOW, 1, 1: active digit select bit = 0
SEG_ACTIVE_LOW, 1, 1: lit segment = 0

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  scan enable; 0 = display dark
load  in  1  one-cycle pulse: capture digit_data/dp_in into shadow register
digit_data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (i = NUM_DIGITS-1 is leftmost)
dp_in  in  NUM_DIGITS  decimal point per digit
digit_mask  in  NUM_DIGITS  1 = digit displayed; 0 = slot time consumed, digit held dark
lz_suppress  in  1  1 = blank leading zeros
sel  out  NUM_DIGITS  digit select, polarity per SEL_ACTIVE_LOW
seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse at end of last slot of a frame

Behaviour:
- Reset (clk edge with rst_n=0, also mid-frame): state IDLE, sel all inactive (4'b1111 default), seg all off (8'hFF default), frame_done 0, prescaler 0, slot NUM_DIGITS-1, shadow and active data registers 0.
- All outputs registered; they change on the same edge as the state/counter update producing them.
- States: IDLE, GUARD, ON.
- IDLE: outputs off. en=1 -> GUARD, slot=NUM_DIGITS-1, prescaler=0, active<=shadow.
- GUARD: sel inactive, seg off; lasts GUARD_CYCLES edges, then -> ON.
- ON: sel bit [slot] active if digit_mask[slot]=1 and digit not suppressed, else all inactive; seg = decode(active nibble[slot]) with dp. Lasts SCAN_DIV-GUARD_CYCLES edges; then slot decrements -> GUARD. After slot 0: frame_done=1 for one cycle, slot wraps to NUM_DIGITS-1, active<=shadow (frame boundary).
- Frame period exactly NUM_DIGITS*SCAN_DIV cycles, independent of mask/suppression.
- en=0 in any state: next edge -> IDLE, outputs off, no frame_done.
- load: shadow<=inputs on that edge. load on the same edge as a frame-boundary transfer: active gets the previous shadow; new data shown next frame. Active never changes mid-frame (no tearing).
- Leading-zero suppression (lz_suppress=1): scanning from digit NUM_DIGITS-1 down, digits with nibble 0 and dp 0 are dark until the first nonzero nibble or set dp; digit 0 is never suppressed. Evaluated on active data.
- Decode: 0-F standard hex glyphs (b, d lowercase). Active-low: '0'=8'hC0, '1'=8'hF9, '8'+dp=8'h00.

Optional Feature:
SEG_SCAN_DIM_EN: adds input brightness[3:0] and a free-running 4-bit pwm counter (reset 0). In ON, the digit is lit only while pwm_cnt <= brightness (15 = full, 0 = 1/16 duty); otherwise sel and seg are inactive. Without the macro: no port, digits fully lit throughout ON.

Decomposition:
- Shared package seg_disp_pkg: state encoding, 16-entry hex-to-segment constant table (active-high), segment bit-index constants.
- Sub-module hex_to_seg7: combinational nibble+dp -> 8-bit active-high pattern; polarity applied in seg_scan_ctrl.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2 unless noted)
1. Reset held 3 cycles, en=1 -> sel=4'b1111, seg=8'hFF during reset; sel=4'b0111 first visible after 3rd edge sampling en=1; pattern 0111,1011,1101,1110 each 6 cycles separated by 2 dark cycles; frame_done every 32 cycles.
2. load digit_data=16'h1230, dp_in=4'b0100 -> next frame: slot3 seg=8'hF9, slot2 seg=decode('2') with dp bit 0, slot0 seg=8'hC0.
3. digit_data=16'h0050, lz_suppress=1 -> digits 3,2 dark (sel 4'b1111 in their slots), digits 1,0 show '5','0'; lz_suppress=0 -> all four lit.
4. digit_mask=4'b1010 -> only sel 4'b0111 and 4'b1101 ever appear; frame_done period still 32.
5. load mid-frame (slot 2) and load coincident with frame boundary -> displayed data changes only at the following frame start; no mixed frame.
6. en dropped in ON, and rst_n pulsed mid-frame -> outputs off on next edge; restart begins at slot 3 with GUARD; with SEG_SCAN_DIM_EN, brightness=3 -> digit lit 4 of every 16 ON cycles.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared scan states, segment bit positions and hex glyph table
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - nibble plus decimal point to active-high segment pattern
module hex_to_seg7
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern[SEG_G:SEG_A] = HEX_SEG_TABLE[nibble];
    assign pattern[SEG_DP]      = dp;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller; SEG_SCAN_DIM_EN adds PWM brightness
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    lz_suppress,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_GUARD_LAST = PW'(GUARD_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST       = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST      = SW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    scan_state_t state, state_nx;
    logic [PW-1:0] prescaler, pre_nx;
    logic [SW-1:0] slot, slot_nx;
    logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
    logic                    xfer, frame_nx;
    logic [NUM_DIGITS-1:0]   blank, sel_nx;
    logic [7:0]              seg_nx, pattern;
    logic                    leading, lit, dim_on;

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwm_cnt;
    logic [3:0] pwm_nx;

    assign pwm_nx = pwm_cnt + 4'd1;
    // Outputs are registered, so gate on the count they will be displayed alongside
    assign dim_on = (pwm_nx <= brightness);

    always_ff @(posedge clk) begin
        if (!rst_n) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_nx;
    end
`else
    assign dim_on = 1'b1;
`endif

    hex_to_seg7 u_dec (
        .nibble  (active_data[{slot, 2'b00} +: 4]),
        .dp      (active_dp[slot]),
        .pattern (pattern)
    );

    // Leading digits stay blank until the first nonzero nibble or set dp; digit 0 always shows
    always_comb begin
        blank   = '0;
        leading = lz_suppress;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (active_data[4*i +: 4] != 4'd0 || active_dp[i]) leading = 1'b0;
            blank[i] = leading;
        end
    end

    assign lit = digit_mask[slot] && !blank[slot] && dim_on;

    always_comb begin
        state_nx = state;
        pre_nx   = prescaler;
        slot_nx  = slot;
        xfer     = 1'b0;
        frame_nx = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_GUARD;
                    pre_nx   = '0;
                    slot_nx  = SLOT_LAST;
                    xfer     = 1'b1;
                end
                ST_GUARD: begin
                    pre_nx = prescaler + PW'(1);
                    if (prescaler == PRE_GUARD_LAST) state_nx = ST_ON;
                end
                ST_ON: begin
                    if (prescaler == PRE_LAST) begin
                        pre_nx   = '0;
                        state_nx = ST_GUARD;
                        if (slot == '0) begin
                            slot_nx  = SLOT_LAST;
                            frame_nx = 1'b1;
                            xfer     = 1'b1;
                        end else begin
                            slot_nx = slot - SW'(1);
                        end
                    end else begin
                        pre_nx = prescaler + PW'(1);
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // ON is only entered from GUARD, so slot and active data are already stable here
    always_comb begin
        sel_nx = SEL_OFF;
        seg_nx = SEG_OFF;
        if (state_nx == ST_ON && dim_on) begin
            seg_nx = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
            if (lit) sel_nx = SEL_OFF ^ (NUM_DIGITS'(1) << slot);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prescaler   <= '0;
            slot        <= SLOT_LAST;
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
            sel         <= SEL_OFF;
            seg         <= SEG_OFF;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            prescaler  <= pre_nx;
            slot       <= slot_nx;
            sel        <= sel_nx;
            seg        <= seg_nx;
            frame_done <= frame_nx;
            if (xfer) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
            end
            if (load) begin
                shadow_data <= digit_data;
                shadow_dp   <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with frame-position reference model
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n, en, load, lz_suppress;
    logic [15:0] digit_data;
    logic [3:0]  dp_in, digit_mask;
    logic [3:0]  brightness;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYCLES(GD),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .digit_data(digit_data), .dp_in(dp_in), .digit_mask(digit_mask),
        .lz_suppress(lz_suppress),
`ifdef SEG_SCAN_DIM_EN
        .brightness(brightness),
`endif
        .sel(sel), .seg(seg), .frame_done(frame_done)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: position t within the running scan decides slot and guard/on phase
    bit          running = 1'b0;
    int          t = 0;
    logic [15:0] m_sh_d, m_act_d;
    logic [3:0]  m_sh_dp, m_act_dp;
    logic [3:0]  m_sel;
    logic [7:0]  m_seg;
    logic        m_fd;

    always @(posedge clk) begin : model
        int s;
        bit lead;
        logic [3:0] nib;
        if (!rst_n) begin
            running = 1'b0;
            m_sh_d = '0; m_sh_dp = '0; m_act_d = '0; m_act_dp = '0;
            m_sel = 4'hF; m_seg = 8'hFF; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (!en) begin
                running = 1'b0;
            end else if (!running) begin
                running = 1'b1;
                t = 0;
                m_act_d = m_sh_d; m_act_dp = m_sh_dp;
            end else begin
                t++;
                if (t % FRAME == 0) begin
                    m_fd = 1'b1;
                    m_act_d = m_sh_d; m_act_dp = m_sh_dp;
                end
            end
            if (load) begin
                m_sh_d = digit_data; m_sh_dp = dp_in;
            end
            m_sel = 4'hF;
            m_seg = 8'hFF;
            if (running && (t % SD) >= GD) begin
                s = ND - 1 - (t / SD) % ND;
                nib = m_act_d[s*4 +: 4];
                lead = lz_suppress && (s > 0);
                for (int j = ND - 1; j >= s; j--)
                    if (m_act_d[j*4 +: 4] != 4'd0 || m_act_dp[j]) lead = 1'b0;
                m_seg = ~{m_act_dp[s], glyph[nib]};
                if (digit_mask[s] && !lead) m_sel = ~(4'(1) << s);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_seg", 32'(seg), 32'(m_seg));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_done && cyc < 100);
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; en = 1'b1; load = 1'b0; lz_suppress = 1'b0;
        digit_data = '0; dp_in = '0; digit_mask = 4'hF; brightness = 4'hF;

        step(3);
        chk("reset_sel", 32'(sel), 32'h0000000F);
        chk("reset_seg", 32'(seg), 32'h000000FF);
        chk("reset_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("guard_dark", 32'(sel), 32'h0000000F);
        step(1);
        chk("first_sel", 32'(sel), 32'h00000007);
        chk("first_seg", 32'(seg), 32'h000000C0);
        wait_fd(c);
        chk("first_frame_done_delay", 32'(c), 32'd30);
        wait_fd(c);
        chk("frame_period", 32'(c), 32'd32);

        digit_data = 16'h1230; dp_in = 4'b0100; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_fd(c);
        step(2);
        chk("slot3_one", 32'(seg), 32'h000000F9);
        chk("slot3_sel", 32'(sel), 32'h00000007);
        step(8);
        chk("slot2_two_dp", 32'(seg), 32'h00000024);
        chk("slot2_sel", 32'(sel), 32'h0000000B);
        step(16);
        chk("slot0_zero", 32'(seg), 32'h000000C0);
        chk("slot0_sel", 32'(sel), 32'h0000000E);

        digit_data = 16'h0050; dp_in = 4'b0000; load = 1'b1; lz_suppress = 1'b1;
        step(1);
        load = 1'b0;
        wait_fd(c);
        step(2);
        chk("lz_slot3_dark", 32'(sel), 32'h0000000F);
        step(8);
        chk("lz_slot2_dark", 32'(sel), 32'h0000000F);
        step(8);
        chk("lz_slot1_sel", 32'(sel), 32'h0000000D);
        chk("lz_slot1_five", 32'(seg), 32'h00000092);
        step(8);
        chk("lz_slot0_sel", 32'(sel), 32'h0000000E);
        lz_suppress = 1'b0;
        step(8);
        chk("nolz_slot3_lit", 32'(sel), 32'h00000007);

        digit_mask = 4'b1010;
        wait_fd(c);
        wait_fd(c);
        chk("masked_frame_period", 32'(c), 32'd32);
        digit_mask = 4'hF;

        step(10);
        digit_data = 16'h4567; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_fd(c);
        step(31);
        digit_data = 16'h89AB; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("boundary_fd", 32'(frame_done), 32'd1);
        step(2);
        chk("boundary_prev_shadow", 32'(seg), 32'h00000099);
        step(32);
        chk("next_frame_new_data", 32'(seg), 32'h00000080);

        en = 1'b0;
        step(1);
        chk("en_off_sel", 32'(sel), 32'h0000000F);
        chk("en_off_seg", 32'(seg), 32'h000000FF);
        en = 1'b1;
        step(1);
        chk("restart_guard", 32'(sel), 32'h0000000F);
        step(2);
        chk("restart_slot3", 32'(sel), 32'h00000007);
        step(12);
        rst_n = 1'b0;
        step(1);
        chk("midreset_sel", 32'(sel), 32'h0000000F);
        chk("midreset_seg", 32'(seg), 32'h000000FF);
        rst_n = 1'b1;
        step(3);
        chk("post_reset_sel", 32'(sel), 32'h00000007);
        chk("post_reset_cleared", 32'(seg), 32'h000000C0);
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
